// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM port arbiter.
package sram_arb_pkg;

   // What the SRAM port did on the previous clock
   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_WRITE,
      S_TURN
   } state_t;

   // Requester indices; index 0 is the real-time VGA fetch port
   localparam int REQ_VGA  = 0;
   localparam int REQ_UART = 1;
   localparam int REQ_M1   = 2;

   // Requester id width, wide enough for up to four requesters
   localparam int ID_W = 2;

   // One entry of the read-return tag pipeline
   typedef struct packed {
      logic            valid;
      logic [ID_W-1:0] id;
   } rd_tag_t;

endpackage

// File: rtl/sram_arb_rr_pick.sv
// Round-robin picker: starting at the rr pointer, returns the first
// asserted request among indices 1..NUM_REQ-1 as a one-hot vector.
// Index 0 is never picked; it is handled by strict priority in the top.
module sram_arb_rr_pick #(
   parameter int NUM_REQ = 3,
   parameter int PTR_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   rr,
   output logic [NUM_REQ-1:0] pick
);

   localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

   // Scan from farthest to nearest so the candidate closest to rr wins
   always_comb begin
      int base;
      int idx;
      logic [NUM_REQ-1:0] cand;
      pick = '0;
      base = (rr == '0) ? 0 : int'(rr) - 1;
      idx  = 1;
      cand = '0;
      for (int k = NUM_REQ - 2; k >= 0; k--) begin
         idx  = ((base + k) % (NUM_REQ - 1)) + 1;
         cand = ONE << idx;
         if ((req & cand) != '0) begin
            pick = cand;
         end
      end
   end

endmodule

// File: rtl/sram_arbiter.sv
// Arbiter for the single external SRAM port. Requester 0 (VGA) has strict
// priority, the others share by round-robin. One access per clock, with a
// one-cycle bubble when a read follows a write. Read data is routed back to
// its requester by a tag pipeline.
// Optional build macro SRAM_ARB_STATS_EN adds per-requester grant and stall
// counters (saturating, 16 bits each).
module sram_arbiter
   import sram_arb_pkg::*;
#(
   parameter int NUM_REQ      = 3,
   parameter int ADDR_W       = 18,
   parameter int DATA_W       = 16,
   parameter int READ_LATENCY = 2
) (
   input  logic                           Clock,
   input  logic                           Resetn,
   input  logic [NUM_REQ-1:0]             req,
   input  logic [NUM_REQ-1:0]             req_we,
   input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]             gnt,
   output logic [NUM_REQ-1:0]             rd_valid,
   output logic [DATA_W-1:0]              rd_data,
   output logic [ADDR_W-1:0]              SRAM_address,
   output logic [DATA_W-1:0]              SRAM_write_data,
   output logic                           SRAM_we_n,
   input  logic [DATA_W-1:0]              SRAM_read_data,
   output logic                           busy
`ifdef SRAM_ARB_STATS_EN
   ,
   output logic [NUM_REQ-1:0][15:0]       grant_count,
   output logic [NUM_REQ-1:0][15:0]       stall_count
`endif
);

   localparam int PTR_W = $clog2(NUM_REQ);
   localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

   state_t             state;
   logic [PTR_W-1:0]   rr;
   rd_tag_t            tag_pipe [READ_LATENCY+1];
   logic [NUM_REQ-1:0] rr_pick;
   logic [NUM_REQ-1:0] win;
   logic [ID_W-1:0]    win_id;
   logic               win_read;
   logic               bubble;

   sram_arb_rr_pick #(
      .NUM_REQ(NUM_REQ),
      .PTR_W  (PTR_W)
   ) u_rr_pick (
      .req ({req[NUM_REQ-1:1], 1'b0}),
      .rr  (rr),
      .pick(rr_pick)
   );

   assign win = req[REQ_VGA] ? ONE : rr_pick;

   // Encode the winner and note whether it wants a read
   always_comb begin
      win_id   = '0;
      win_read = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win[i]) begin
            win_id   = ID_W'(i);
            win_read = ~req_we[i];
         end
      end
   end

   assign bubble = (state == S_WRITE) && (win != '0) && win_read;

   // Grant the winner unless in reset or inserting the write-to-read bubble
   always_comb begin
      gnt = '0;
      if (Resetn && !bubble) begin
         gnt = win;
      end
   end

   // Port FSM: register the granted access and advance the rr pointer
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state           <= S_IDLE;
         rr              <= PTR_W'(REQ_UART);
         SRAM_address    <= '0;
         SRAM_write_data <= '0;
         SRAM_we_n       <= 1'b1;
      end else if (bubble) begin
         state     <= S_TURN;
         SRAM_we_n <= 1'b1;
      end else if (gnt != '0) begin
         state           <= win_read ? S_READ : S_WRITE;
         SRAM_address    <= req_addr[win_id];
         SRAM_write_data <= req_wdata[win_id];
         SRAM_we_n       <= win_read;
         if (!gnt[REQ_VGA]) begin
            rr <= (win_id == ID_W'(NUM_REQ - 1)) ? PTR_W'(REQ_UART)
                                                  : PTR_W'(win_id + ID_W'(1));
         end
      end else begin
         state     <= S_IDLE;
         SRAM_we_n <= 1'b1;
      end
   end

   // Tag pipeline follows each read to its return slot; capture data alongside
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         for (int i = 0; i <= READ_LATENCY; i++) begin
            tag_pipe[i] <= '0;
         end
         rd_data <= '0;
      end else begin
         tag_pipe[0].valid <= (gnt != '0) && win_read;
         tag_pipe[0].id    <= win_id;
         for (int i = 1; i <= READ_LATENCY; i++) begin
            tag_pipe[i] <= tag_pipe[i-1];
         end
         if (tag_pipe[READ_LATENCY-1].valid) begin
            rd_data <= SRAM_read_data;
         end
      end
   end

   // Decode the last tag stage into the one-hot return strobe
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         rd_valid[i] = tag_pipe[READ_LATENCY].valid &&
                       (tag_pipe[READ_LATENCY].id == ID_W'(i));
      end
   end

   // Busy while granting or while a read is still on its way back
   always_comb begin
      busy = (gnt != '0);
      for (int i = 0; i < READ_LATENCY; i++) begin
         if (tag_pipe[i].valid) begin
            busy = 1'b1;
         end
      end
   end

`ifdef SRAM_ARB_STATS_EN
   // Saturating per-requester grant and stall counters
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         grant_count <= '0;
         stall_count <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i] && (grant_count[i] != 16'hFFFF)) begin
               grant_count[i] <= grant_count[i] + 16'd1;
            end
            if (req[i] && !gnt[i] && (stall_count[i] != 16'hFFFF)) begin
               stall_count[i] <= stall_count[i] + 16'd1;
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// Testbench for sram_arbiter: table of per-cycle arbitration vectors plus
// hand-written sequences for read return, write/read turnaround, reset
// during a read and (with SRAM_ARB_STATS_EN) the statistics counters.
module tb_sram_arbiter;

   logic             Clock;
   logic             Resetn;
   logic [2:0]       req;
   logic [2:0]       req_we;
   logic [2:0][17:0] req_addr;
   logic [2:0][15:0] req_wdata;
   logic [2:0]       gnt;
   logic [2:0]       rd_valid;
   logic [15:0]      rd_data;
   logic [17:0]      SRAM_address;
   logic [15:0]      SRAM_write_data;
   logic             SRAM_we_n;
   logic [15:0]      SRAM_read_data;
   logic             busy;
`ifdef SRAM_ARB_STATS_EN
   logic [2:0][15:0] grant_count;
   logic [2:0][15:0] stall_count;
`endif

   int testsRun;
   int testsFailed;

   typedef struct {
      logic [2:0] req;
      logic [2:0] we;
      logic [2:0] gnt;
      logic       we_n;
      logic       busy;
   } vec_t;

   vec_t vecs [15];

   logic [15:0] mem [0:(1<<18)-1];

   sram_arbiter #(
      .NUM_REQ(3),
      .ADDR_W(18),
      .DATA_W(16),
      .READ_LATENCY(2)
   ) dut (
      .Clock          (Clock),
      .Resetn         (Resetn),
      .req            (req),
      .req_we         (req_we),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .gnt            (gnt),
      .rd_valid       (rd_valid),
      .rd_data        (rd_data),
      .SRAM_address   (SRAM_address),
      .SRAM_write_data(SRAM_write_data),
      .SRAM_we_n      (SRAM_we_n),
      .SRAM_read_data (SRAM_read_data),
      .busy           (busy)
`ifdef SRAM_ARB_STATS_EN
      ,
      .grant_count    (grant_count),
      .stall_count    (stall_count)
`endif
   );

   // 100 MHz-style free-running clock
   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   // SRAM interface model: write on we_n low, read data one edge after the address edge
   always @(posedge Clock) begin
      if (!Resetn) begin
         mem[18'h00100] <= 16'hABCD;
      end else if (!SRAM_we_n) begin
         mem[SRAM_address] <= SRAM_write_data;
      end
      SRAM_read_data <= mem[SRAM_address];
   end

   // Global watchdog
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time exceeded, got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic applyStimulus(input logic [2:0] r, input logic [2:0] w);
      @(negedge Clock);
      req    = r;
      req_we = w;
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin
      logic [2:0] seen;
      testsRun    = 0;
      testsFailed = 0;
      Resetn      = 1'b0;
      req         = 3'b111;
      req_we      = 3'b000;
      for (int i = 0; i < 3; i++) begin
         req_addr[i]  = 18'h00010 + 18'(i);
         req_wdata[i] = 16'h5A00 + 16'(i);
      end

      // req, we, expected gnt, expected SRAM_we_n, expected busy
      vecs[0]  = '{3'b111, 3'b000, 3'b001, 1'b1, 1'b1};
      vecs[1]  = '{3'b111, 3'b000, 3'b001, 1'b1, 1'b1};
      vecs[2]  = '{3'b110, 3'b000, 3'b010, 1'b1, 1'b1};
      vecs[3]  = '{3'b110, 3'b000, 3'b100, 1'b1, 1'b1};
      vecs[4]  = '{3'b110, 3'b000, 3'b010, 1'b1, 1'b1};
      vecs[5]  = '{3'b000, 3'b000, 3'b000, 1'b1, 1'b1};
      vecs[6]  = '{3'b010, 3'b010, 3'b010, 1'b1, 1'b1};
      vecs[7]  = '{3'b100, 3'b100, 3'b100, 1'b0, 1'b1};
      vecs[8]  = '{3'b010, 3'b000, 3'b000, 1'b0, 1'b0};
      vecs[9]  = '{3'b010, 3'b000, 3'b010, 1'b1, 1'b1};
      vecs[10] = '{3'b101, 3'b000, 3'b001, 1'b1, 1'b1};
      vecs[11] = '{3'b110, 3'b110, 3'b100, 1'b1, 1'b1};
      vecs[12] = '{3'b001, 3'b000, 3'b000, 1'b0, 1'b1};
      vecs[13] = '{3'b001, 3'b000, 3'b001, 1'b1, 1'b1};
      vecs[14] = '{3'b000, 3'b000, 3'b000, 1'b1, 1'b1};

      // Reset held with every requester asking
      repeat (3) @(negedge Clock);
      #1;
      checkOutput("reset_gnt", 32'(gnt), 32'h0);
      checkOutput("reset_we_n", 32'(SRAM_we_n), 32'h1);
      checkOutput("reset_busy", 32'(busy), 32'h0);
      checkOutput("reset_rd_valid", 32'(rd_valid), 32'h0);
      checkOutput("reset_addr", 32'(SRAM_address), 32'h0);

      // Table: first vector is the cycle reset is released
      for (int i = 0; i < 15; i++) begin
         @(negedge Clock);
         Resetn = 1'b1;
         req    = vecs[i].req;
         req_we = vecs[i].we;
         #1;
         checkOutput($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(vecs[i].gnt));
         checkOutput($sformatf("vec%0d_we_n", i), 32'(SRAM_we_n), 32'(vecs[i].we_n));
         checkOutput($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
      end

      // Drain outstanding reads
      repeat (4) applyStimulus(3'b000, 3'b000);
      checkOutput("idle_busy", 32'(busy), 32'h0);

      // Read return from requester 2
      req_addr[2] = 18'h00100;
      applyStimulus(3'b100, 3'b000);
      checkOutput("rd_gnt", 32'(gnt), 32'h4);
      applyStimulus(3'b000, 3'b000);
      checkOutput("rd_addr", 32'(SRAM_address), 32'h100);
      checkOutput("rd_we_n", 32'(SRAM_we_n), 32'h1);
      checkOutput("rd_valid_t1", 32'(rd_valid), 32'h0);
      applyStimulus(3'b000, 3'b000);
      checkOutput("rd_valid_t2", 32'(rd_valid), 32'h0);
      applyStimulus(3'b000, 3'b000);
      checkOutput("rd_valid_t3", 32'(rd_valid), 32'h4);
      checkOutput("rd_data_t3", 32'(rd_data), 32'hABCD);
      applyStimulus(3'b000, 3'b000);
      checkOutput("rd_valid_t4", 32'(rd_valid), 32'h0);

      // Write then read of the same address needs one bubble
      req_addr[1]  = 18'd5;
      req_wdata[1] = 16'h1234;
      req_addr[2]  = 18'd5;
      applyStimulus(3'b010, 3'b010);
      checkOutput("ta_wr_gnt", 32'(gnt), 32'h2);
      applyStimulus(3'b100, 3'b000);
      checkOutput("ta_bubble_gnt", 32'(gnt), 32'h0);
      checkOutput("ta_wr_addr", 32'(SRAM_address), 32'h5);
      checkOutput("ta_wr_data", 32'(SRAM_write_data), 32'h1234);
      checkOutput("ta_wr_we_n", 32'(SRAM_we_n), 32'h0);
      applyStimulus(3'b100, 3'b000);
      checkOutput("ta_rd_gnt", 32'(gnt), 32'h4);
      applyStimulus(3'b000, 3'b000);
      applyStimulus(3'b000, 3'b000);
      checkOutput("ta_rd_valid_early", 32'(rd_valid), 32'h0);
      applyStimulus(3'b000, 3'b000);
      checkOutput("ta_rd_valid", 32'(rd_valid), 32'h4);
      checkOutput("ta_rd_data", 32'(rd_data), 32'h1234);

      // Reset while a read is in flight drops its return
      applyStimulus(3'b010, 3'b000);
      checkOutput("rst_rd_gnt", 32'(gnt), 32'h2);
      @(negedge Clock);
      req    = 3'b000;
      Resetn = 1'b0;
      #1;
      checkOutput("rst_mid_busy", 32'(busy), 32'h0);
      @(negedge Clock);
      Resetn = 1'b1;
      seen   = 3'b000;
      for (int k = 0; k < 5; k++) begin
         @(negedge Clock);
         #1;
         seen = seen | rd_valid;
      end
      checkOutput("rst_no_rd_valid", 32'(seen), 32'h0);
      applyStimulus(3'b110, 3'b000);
      checkOutput("rst_rr_ptr", 32'(gnt), 32'h2);

`ifdef SRAM_ARB_STATS_EN
      // Requester 1 starved by requester 0 for ten cycles
      @(negedge Clock);
      req    = 3'b000;
      Resetn = 1'b0;
      @(negedge Clock);
      Resetn = 1'b1;
      for (int k = 0; k < 10; k++) begin
         applyStimulus(3'b011, 3'b000);
         checkOutput($sformatf("stat_gnt%0d", k), 32'(gnt), 32'h1);
      end
      applyStimulus(3'b000, 3'b000);
      checkOutput("stat_grant0", 32'(grant_count[0]), 32'd10);
      checkOutput("stat_stall1", 32'(stall_count[1]), 32'd10);
      checkOutput("stat_grant1", 32'(grant_count[1]), 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
